// File: rtl/robot_pkg.sv
// Shared types and constants for the wall-following trash-clearing robot controller.
package robot_pkg;

  typedef enum logic [2:0] {
    FIRST_MOVE = 3'd0,
    SEARCH     = 3'd1,
    ROTATE     = 3'd2,
    REMOVE     = 3'd3,
    STANDBY    = 3'd4,
    STUCK      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ActNone,
    ActFront,
    ActSideTurn,
    ActAwayTurn,
    ActRemove
  } action_e;

  localparam logic TURN_CCW = 1'b0;
  localparam logic TURN_CW  = 1'b1;

  localparam int unsigned HAND_LEFT  = 0;
  localparam int unsigned HAND_RIGHT = 1;

endpackage

// File: rtl/robot_remove_timer.sv
// Down-counter timing one trash removal; expired_o is high once the remove budget is spent.
module robot_remove_timer #(
  parameter int unsigned Cycles = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic abort_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_d, cnt_q;

  // start_i coincides with the first remove cycle, so only Cycles-1 more remain.
  always_comb begin
    cnt_d = cnt_q;
    if (abort_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = CntW'(Cycles - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/robot_ctrl_p.sv
// Wall-following robot controller: picks one registered action per cycle from wall,
// trash and exit sensors, clears trash, and flags exit or a stuck condition.
module robot_ctrl_p
  import robot_pkg::*;
#(
  parameter int unsigned REMOVE_CYCLES = 3,
  parameter int unsigned STUCK_LIMIT   = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned HAND          = HAND_LEFT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             head,
  input  logic             side,
  input  logic             barrier,
  input  logic             under,
  output logic             front,
  output logic             turn,
  output logic             turn_dir,
  output logic             remove,
  output logic             stuck,
  output logic             done,
  output logic [CNT_W-1:0] move_count
);

  localparam logic        SideDir = (HAND == HAND_RIGHT) ? TURN_CW : TURN_CCW;
  localparam logic        AwayDir = (HAND == HAND_RIGHT) ? TURN_CCW : TURN_CW;
  localparam int unsigned TcW     = $clog2(STUCK_LIMIT + 1);

  state_e  act_state, next_state;
  action_e rule_act, act;

  logic             side_turn_d, side_turn_q;
  logic [TcW-1:0]   turn_cnt_d, turn_cnt_q;
  logic [CNT_W-1:0] move_count_d, move_count_q;
  logic             front_d, front_q, turn_d, turn_q, turn_dir_d, turn_dir_q;
  logic             remove_d, remove_q, stuck_d, stuck_q, done_d, done_q;
  logic             timer_start, timer_abort, timer_expired;

  // The first move has no wall to follow yet, so it never takes a side-turn.
  always_comb begin
    rule_act = ActAwayTurn;
    if (barrier) begin
      rule_act = ActRemove;
    end else if (!side && !side_turn_q && (act_state != FIRST_MOVE)) begin
      rule_act = ActSideTurn;
    end else if (!head) begin
      rule_act = ActFront;
    end
  end

  always_comb begin
    next_state = act_state;
    act        = ActNone;
    case (act_state)
      FIRST_MOVE, SEARCH, ROTATE, REMOVE: begin
        if (under) begin
          next_state = STANDBY;
        end else if (turn_cnt_q >= TcW'(STUCK_LIMIT)) begin
          next_state = STUCK;
        end else if ((act_state == REMOVE) && barrier && timer_expired) begin
          next_state = SEARCH;
        end else begin
          act = rule_act;
          case (rule_act)
            ActRemove: next_state = REMOVE;
            ActFront:  next_state = SEARCH;
            default:   next_state = ROTATE;
          endcase
          if ((act_state == FIRST_MOVE) && (rule_act != ActRemove)) begin
            next_state = side ? SEARCH : FIRST_MOVE;
          end
        end
      end
      default: ;
    endcase
  end

  assign timer_start = (act == ActRemove) && (act_state != REMOVE);
  assign timer_abort = (act_state == REMOVE) && (next_state != REMOVE);

  always_comb begin
    front_d      = (act == ActFront);
    turn_d       = (act == ActSideTurn) || (act == ActAwayTurn);
    turn_dir_d   = (act == ActSideTurn) ? SideDir : ((act == ActAwayTurn) ? AwayDir : 1'b0);
    remove_d     = (act == ActRemove);
    side_turn_d  = (act == ActSideTurn);
    done_d       = done_q | (next_state == STANDBY);
    stuck_d      = stuck_q | (next_state == STUCK);

    turn_cnt_d = turn_cnt_q;
    if (front_d) begin
      turn_cnt_d = '0;
    end else if (turn_d && (turn_cnt_q < TcW'(STUCK_LIMIT))) begin
      turn_cnt_d = turn_cnt_q + 1'b1;
    end

    move_count_d = move_count_q;
    if (front_d && (move_count_q != {CNT_W{1'b1}})) begin
      move_count_d = move_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_state    <= FIRST_MOVE;
      side_turn_q  <= 1'b0;
      turn_cnt_q   <= '0;
      move_count_q <= '0;
      front_q      <= 1'b0;
      turn_q       <= 1'b0;
      turn_dir_q   <= 1'b0;
      remove_q     <= 1'b0;
      stuck_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      act_state    <= next_state;
      side_turn_q  <= side_turn_d;
      turn_cnt_q   <= turn_cnt_d;
      move_count_q <= move_count_d;
      front_q      <= front_d;
      turn_q       <= turn_d;
      turn_dir_q   <= turn_dir_d;
      remove_q     <= remove_d;
      stuck_q      <= stuck_d;
      done_q       <= done_d;
    end
  end

  robot_remove_timer #(
    .Cycles(REMOVE_CYCLES)
  ) u_remove_timer (
    .clk_i    (clock),
    .rst_ni   (reset),
    .start_i  (timer_start),
    .abort_i  (timer_abort),
    .expired_o(timer_expired)
  );

  assign front      = front_q;
  assign turn       = turn_q;
  assign turn_dir   = turn_dir_q;
  assign remove     = remove_q;
  assign stuck      = stuck_q;
  assign done       = done_q;
  assign move_count = move_count_q;

endmodule
